multicycle_control: RTL and testbench

Multicycle control unit for the teaching MIPS-style datapath. It sequences each instruction through fetch, decode, execute, memory and write-back states. It stalls on a `mem_ready` handshake from the shared instruction/data memory and drives the datapath enables and multiplexer selects as Moore outputs. It supports the existing opcode set (R-type 4, addiu 12, subiu 13, sw 16, lw 17), traps illegal opcodes, and optionally counts retired instructions.

---
 rtl/mc_ctrl_pkg.sv | 41 ++++
 rtl/mc_main_decoder.sv | 23 ++
 rtl/multicycle_control.sv | 150 +++++++++++++++
 tb/tb_multicycle_control.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_ctrl_pkg.sv
// rtl/mc_ctrl_pkg.sv - shared states, opcodes, ALU/select encodings and instruction classes
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    FETCH    = 4'd1,
    DECODE   = 4'd2,
    EXEC_R   = 4'd3,
    EXEC_I   = 4'd4,
    MEM_ADDR = 4'd5,
    MEM_RD   = 4'd6,
    MEM_WR   = 4'd7,
    WB_ALU   = 4'd8,
    WB_MEM   = 4'd9,
    TRAP     = 4'd10
  } state_e;

  localparam int OP_RTYPE = 4;
  localparam int OP_ADDIU = 12;
  localparam int OP_SUBIU = 13;
  localparam int OP_SW    = 16;
  localparam int OP_LW    = 17;

  localparam logic [1:0] ALU_SUB   = 2'b00;
  localparam logic [1:0] ALU_ADD   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_RT   = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;

  typedef enum logic [2:0] {
    CLS_NONE  = 3'd0,
    CLS_RTYPE = 3'd1,
    CLS_ADDIU = 3'd2,
    CLS_SUBIU = 3'd3,
    CLS_LW    = 3'd4,
    CLS_SW    = 3'd5
  } instrClass_e;

endpackage

// File: rtl/mc_main_decoder.sv
// rtl/mc_main_decoder.sv - combinational opcode to instruction class, flags unknown opcodes
module mc_main_decoder
  import mc_ctrl_pkg::*;
#(
  parameter int OP_W = 6
) (
  input  logic [OP_W-1:0] op,
  output logic [2:0]      opClass,
  output logic            illegal
);

  always_comb begin
    opClass = CLS_NONE;
    illegal = 1'b0;
    if (op == OP_W'(OP_RTYPE))      opClass = CLS_RTYPE;
    else if (op == OP_W'(OP_ADDIU)) opClass = CLS_ADDIU;
    else if (op == OP_W'(OP_SUBIU)) opClass = CLS_SUBIU;
    else if (op == OP_W'(OP_LW))    opClass = CLS_LW;
    else if (op == OP_W'(OP_SW))    opClass = CLS_SW;
    else                            illegal = 1'b1;
  end

endmodule

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multicycle MIPS-style control FSM; MC_CTRL_PERF_EN adds a retired-instruction counter
module multicycle_control
  import mc_ctrl_pkg::*;
#(
  parameter int OP_W    = 6,
  parameter int ALUOP_W = 2,
  parameter int CNT_W   = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run,
  input  logic [OP_W-1:0]    op,
  input  logic               mem_ready,
  output logic               pc_write,
  output logic               ir_write,
  output logic               i_or_d,
  output logic               mem_read,
  output logic               mem_write,
  output logic               mem_to_reg,
  output logic               reg_dst,
  output logic               reg_write,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [ALUOP_W-1:0] alu_op,
  output logic               instr_done,
  output logic               illegal_op,
  output logic [3:0]         state,
  output logic [CNT_W-1:0]   retired
);

  state_e      cur;
  instrClass_e cls;
  logic [2:0]  decClass;
  logic        decIllegal;
  logic [1:0]  aluOpCode;

  mc_main_decoder #(.OP_W(OP_W)) uDecoder (
    .op      (op),
    .opClass (decClass),
    .illegal (decIllegal)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      cur <= IDLE;
      cls <= CLS_NONE;
    end else begin
      case (cur)
        IDLE:     if (run) cur <= FETCH;
        FETCH:    if (mem_ready) cur <= DECODE;
        DECODE: begin
          cls <= instrClass_e'(decClass);
          if (decIllegal) cur <= TRAP;
          else begin
            case (instrClass_e'(decClass))
              CLS_RTYPE:            cur <= EXEC_R;
              CLS_ADDIU, CLS_SUBIU: cur <= EXEC_I;
              default:              cur <= MEM_ADDR;
            endcase
          end
        end
        EXEC_R, EXEC_I: cur <= WB_ALU;
        MEM_ADDR: cur <= (cls == CLS_LW) ? MEM_RD : MEM_WR;
        MEM_RD:   if (mem_ready) cur <= WB_MEM;
        MEM_WR:   if (mem_ready) cur <= run ? FETCH : IDLE;
        WB_ALU, WB_MEM: cur <= run ? FETCH : IDLE;
        TRAP:     cur <= TRAP;
        default:  cur <= IDLE;
      endcase
    end
  end

  // Moore decode of the registered state; only the handshake-completing strobes see mem_ready
  always_comb begin
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    i_or_d     = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_to_reg = 1'b0;
    reg_dst    = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_RT;
    aluOpCode  = ALU_SUB;
    instr_done = 1'b0;
    illegal_op = 1'b0;
    case (cur)
      FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRCB_FOUR;
        aluOpCode = ALU_ADD;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      EXEC_R: begin
        alu_src_a = 1'b1;
        aluOpCode = ALU_FUNCT;
      end
      EXEC_I: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        aluOpCode = (cls == CLS_SUBIU) ? ALU_SUB : ALU_ADD;
      end
      MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        aluOpCode = ALU_ADD;
      end
      MEM_RD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
      end
      MEM_WR: begin
        mem_write  = 1'b1;
        i_or_d     = 1'b1;
        instr_done = mem_ready;
      end
      WB_ALU: begin
        reg_write  = 1'b1;
        reg_dst    = (cls == CLS_RTYPE);
        instr_done = 1'b1;
      end
      WB_MEM: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        instr_done = 1'b1;
      end
      TRAP:    illegal_op = 1'b1;
      default: ;
    endcase
  end

  assign alu_op = ALUOP_W'(aluOpCode);
  assign state  = cur;

`ifdef MC_CTRL_PERF_EN
  logic [CNT_W-1:0] retCnt;

  always_ff @(posedge clk) begin
    if (rst)             retCnt <= '0;
    else if (instr_done) retCnt <= retCnt + CNT_W'(1);
  end

  assign retired = retCnt;
`else
  assign retired = '0;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - directed vector table, corner sequences and randomized run against a phase-script model
module tb_multicycle_control;

  localparam int CW = 2;
`ifdef MC_CTRL_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst, run, mem_ready;
  logic [5:0] op;
  logic pc_write, ir_write, i_or_d, mem_read, mem_write, mem_to_reg;
  logic reg_dst, reg_write, alu_src_a, instr_done, illegal_op;
  logic [1:0] alu_src_b, alu_op;
  logic [3:0] state;
  logic [CW-1:0] retired;

  multicycle_control #(.OP_W(6), .ALUOP_W(2), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .run(run), .op(op), .mem_ready(mem_ready),
    .pc_write(pc_write), .ir_write(ir_write), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .mem_to_reg(mem_to_reg),
    .reg_dst(reg_dst), .reg_write(reg_write), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .instr_done(instr_done),
    .illegal_op(illegal_op), .state(state), .retired(retired)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] st;
    logic pcW, irW, iod, mr, mw, m2r, rd, rw, sa;
    logic [1:0] sb, aop;
    logic done, ill;
  } obs_t;

  obs_t act;
  assign act = {state, pc_write, ir_write, i_or_d, mem_read, mem_write, mem_to_reg,
                reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, instr_done, illegal_op};

  int total = 0;
  int bad = 0;

  // expected outputs of each state, with mem_ready assumed high
  function automatic obs_t fIdle(); obs_t o = '0; return o; endfunction
  function automatic obs_t fFetch();
    obs_t o = '0; o.st = 4'd1; o.mr = 1; o.sb = 2'b01; o.aop = 2'b01; o.pcW = 1; o.irW = 1; return o;
  endfunction
  function automatic obs_t fDecode(); obs_t o = '0; o.st = 4'd2; return o; endfunction
  function automatic obs_t fExecR();
    obs_t o = '0; o.st = 4'd3; o.sa = 1; o.sb = 2'b00; o.aop = 2'b10; return o;
  endfunction
  function automatic obs_t fExecI(input bit sub);
    obs_t o = '0; o.st = 4'd4; o.sa = 1; o.sb = 2'b10; o.aop = sub ? 2'b00 : 2'b01; return o;
  endfunction
  function automatic obs_t fMemAddr();
    obs_t o = '0; o.st = 4'd5; o.sa = 1; o.sb = 2'b10; o.aop = 2'b01; return o;
  endfunction
  function automatic obs_t fMemRd(); obs_t o = '0; o.st = 4'd6; o.mr = 1; o.iod = 1; return o; endfunction
  function automatic obs_t fMemWr();
    obs_t o = '0; o.st = 4'd7; o.mw = 1; o.iod = 1; o.done = 1; return o;
  endfunction
  function automatic obs_t fWbAlu(input bit r);
    obs_t o = '0; o.st = 4'd8; o.rw = 1; o.rd = r; o.done = 1; return o;
  endfunction
  function automatic obs_t fWbMem();
    obs_t o = '0; o.st = 4'd9; o.rw = 1; o.m2r = 1; o.done = 1; return o;
  endfunction
  function automatic obs_t fTrap(); obs_t o = '0; o.st = 4'd10; o.ill = 1; return o; endfunction
  function automatic obs_t gate(input obs_t o, input logic m);
    obs_t g = o;
    if (!m) begin g.pcW = 0; g.irW = 0; g.done = 0; end
    return g;
  endfunction

  task automatic drive(input logic r, input logic ru, input logic [5:0] o, input logic m);
    rst = r; run = ru; op = o; mem_ready = m;
    #1;
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, a, e);
    end
  endtask
  function automatic logic [31:0] expRet(input int unsigned n);
    return PERF ? 32'(n % (1 << CW)) : 32'd0;
  endfunction

  // directed vectors: one entry per clock cycle
  typedef struct {
    logic rst, run;
    logic [5:0] op;
    logic mr;
    obs_t exp;
  } vec_t;
  vec_t tbl[$];
  function automatic vec_t mkv(input logic r, input logic ru, input logic [5:0] o,
                               input logic m, input obs_t e);
    vec_t v; v.rst = r; v.run = ru; v.op = o; v.mr = m; v.exp = e; return v;
  endfunction

  // reference model: a script of phases still to run for the current instruction
  typedef struct packed { obs_t o; logic waits; logic isDecode; } phase_t;
  phase_t q[$];
  bit trapped;
  int unsigned cnt;

  function automatic phase_t ph(input obs_t o, input logic w, input logic d);
    phase_t p; p.o = o; p.waits = w; p.isDecode = d; return p;
  endfunction
  function automatic void startInstr();
    q.push_back(ph(fFetch(), 1, 0));
    q.push_back(ph(fDecode(), 0, 1));
  endfunction
  function automatic obs_t modelOut(input logic m);
    if (trapped) return fTrap();
    if (q.size() == 0) return fIdle();
    return q[0].waits ? gate(q[0].o, m) : q[0].o;
  endfunction
  function automatic void modelStep(input logic r, input logic ru, input logic [5:0] o, input logic m);
    phase_t cur;
    if (r) begin q.delete(); trapped = 0; cnt = 0; return; end
    if (trapped) return;
    if (q.size() == 0) begin if (ru) startInstr(); return; end
    cur = q[0];
    if (cur.waits && !m) return;
    void'(q.pop_front());
    if (cur.isDecode) begin
      case (o)
        6'd4:  begin q.push_back(ph(fExecR(), 0, 0)); q.push_back(ph(fWbAlu(1), 0, 0)); end
        6'd12: begin q.push_back(ph(fExecI(0), 0, 0)); q.push_back(ph(fWbAlu(0), 0, 0)); end
        6'd13: begin q.push_back(ph(fExecI(1), 0, 0)); q.push_back(ph(fWbAlu(0), 0, 0)); end
        6'd17: begin
          q.push_back(ph(fMemAddr(), 0, 0));
          q.push_back(ph(fMemRd(), 1, 0));
          q.push_back(ph(fWbMem(), 0, 0));
        end
        6'd16: begin q.push_back(ph(fMemAddr(), 0, 0)); q.push_back(ph(fMemWr(), 1, 0)); end
        default: trapped = 1;
      endcase
    end
    if (cur.o.done) begin
      cnt++;
      if (ru) startInstr();
    end
  endfunction

  initial begin
    int unsigned n;
    logic r, ru, m;
    logic [5:0] o;
    obs_t e;

    // R-type, then lw with two MEM_RD stalls, sw with a fetch stall, subiu ending with run=0
    tbl.push_back(mkv(0, 0, 6'd0,  0, fIdle()));
    tbl.push_back(mkv(0, 1, 6'd4,  1, fIdle()));
    tbl.push_back(mkv(0, 1, 6'd4,  1, fFetch()));
    tbl.push_back(mkv(0, 0, 6'd4,  1, fDecode()));
    tbl.push_back(mkv(0, 0, 6'd4,  1, fExecR()));
    tbl.push_back(mkv(0, 1, 6'd4,  0, fWbAlu(1)));
    tbl.push_back(mkv(0, 1, 6'd17, 1, fFetch()));
    tbl.push_back(mkv(0, 1, 6'd17, 1, fDecode()));
    tbl.push_back(mkv(0, 1, 6'd0,  1, fMemAddr()));
    tbl.push_back(mkv(0, 1, 6'd0,  0, fMemRd()));
    tbl.push_back(mkv(0, 0, 6'd0,  0, fMemRd()));
    tbl.push_back(mkv(0, 0, 6'd0,  1, fMemRd()));
    tbl.push_back(mkv(0, 1, 6'd0,  0, fWbMem()));
    tbl.push_back(mkv(0, 1, 6'd16, 0, gate(fFetch(), 0)));
    tbl.push_back(mkv(0, 1, 6'd16, 1, fFetch()));
    tbl.push_back(mkv(0, 1, 6'd16, 1, fDecode()));
    tbl.push_back(mkv(0, 1, 6'd0,  1, fMemAddr()));
    tbl.push_back(mkv(0, 1, 6'd0,  0, gate(fMemWr(), 0)));
    tbl.push_back(mkv(0, 1, 6'd0,  1, fMemWr()));
    tbl.push_back(mkv(0, 1, 6'd13, 1, fFetch()));
    tbl.push_back(mkv(0, 1, 6'd13, 1, fDecode()));
    tbl.push_back(mkv(0, 1, 6'd0,  1, fExecI(1)));
    tbl.push_back(mkv(0, 0, 6'd0,  1, fWbAlu(0)));
    tbl.push_back(mkv(0, 0, 6'd0,  1, fIdle()));
    tbl.push_back(mkv(0, 1, 6'd5,  1, fIdle()));
    tbl.push_back(mkv(0, 1, 6'd5,  1, fFetch()));
    tbl.push_back(mkv(0, 1, 6'd5,  1, fDecode()));

    drive(1, 0, 6'd0, 0);
    tick();
    tick();
    n = 0;
    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].run, tbl[i].op, tbl[i].mr);
      chk($sformatf("vec%0d", i), 32'(act), 32'(tbl[i].exp));
      chk($sformatf("vec%0d_retired", i), 32'(retired), expRet(n));
      if (tbl[i].exp.done && !tbl[i].rst) n++;
      tick();
    end

    // TRAP is absorbing regardless of run/op/mem_ready
    for (int i = 0; i < 12; i++) begin
      drive(0, 1, 6'($urandom_range(0, 63)), 1'($urandom_range(0, 1)));
      chk($sformatf("trap%0d", i), 32'(act), 32'(fTrap()));
      tick();
    end
    drive(1, 1, 6'd4, 1);
    tick();
    drive(0, 0, 6'd0, 0);
    chk("trap_cleared", 32'(act), 32'(fIdle()));
    chk("trap_cleared_retired", 32'(retired), 32'd0);

    // reset while MEM_WR completes: retirement is not counted, enables drop next cycle
    drive(0, 1, 6'd16, 1); tick();
    drive(0, 1, 6'd16, 1); tick();
    drive(0, 1, 6'd16, 1); tick();
    drive(0, 1, 6'd16, 1); tick();
    drive(0, 1, 6'd16, 0);
    chk("memwr_wait", 32'(act), 32'(gate(fMemWr(), 0)));
    tick();
    drive(1, 1, 6'd16, 1);
    chk("memwr_rst_cycle", 32'(act), 32'(fMemWr()));
    tick();
    drive(0, 0, 6'd0, 0);
    chk("memwr_after_rst", 32'(act), 32'(fIdle()));
    chk("memwr_after_rst_retired", 32'(retired), 32'd0);

    // randomized run against the model
    drive(1, 0, 6'd0, 0);
    tick();
    q.delete(); trapped = 0; cnt = 0;
    for (int c = 0; c < 4000; c++) begin
      r  = ($urandom_range(0, 99) < 2);
      ru = ($urandom_range(0, 99) < 85);
      m  = ($urandom_range(0, 99) < 60);
      case ($urandom_range(0, 20))
        0, 1, 2, 3:     o = 6'd4;
        4, 5, 6:        o = 6'd12;
        7, 8, 9:        o = 6'd13;
        10, 11, 12, 13: o = 6'd16;
        14, 15, 16, 17: o = 6'd17;
        18, 19:         o = 6'($urandom_range(0, 63));
        default:        o = 6'd5;
      endcase
      drive(r, ru, o, m);
      e = modelOut(m);
      chk($sformatf("rand%0d", c), 32'(act), 32'(e));
      chk($sformatf("rand%0d_retired", c), 32'(retired), expRet(cnt));
      modelStep(r, ru, o, m);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
